// File: rtl/alu_stage_pkg.sv
// ============================================================================
// alu_stage_pkg : op encodings and widths shared by the ALU execution stage
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_stage_pkg;

  localparam int OP_SIZE_LOG  = 6;
  localparam int ROB_SIZE_LOG = 4;

  localparam logic [OP_SIZE_LOG-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_SIZE_LOG-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_SIZE_LOG-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_SIZE_LOG-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_SIZE_LOG-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_SIZE_LOG-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_SIZE_LOG-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_SIZE_LOG-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_SIZE_LOG-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_SIZE_LOG-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_SIZE_LOG-1:0] OP_ADDI  = 6'd11;
  localparam logic [OP_SIZE_LOG-1:0] OP_SLTI  = 6'd12;
  localparam logic [OP_SIZE_LOG-1:0] OP_SLTIU = 6'd13;
  localparam logic [OP_SIZE_LOG-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_SIZE_LOG-1:0] OP_ORI   = 6'd15;
  localparam logic [OP_SIZE_LOG-1:0] OP_ANDI  = 6'd16;
  localparam logic [OP_SIZE_LOG-1:0] OP_SLLI  = 6'd17;
  localparam logic [OP_SIZE_LOG-1:0] OP_SRLI  = 6'd18;
  localparam logic [OP_SIZE_LOG-1:0] OP_SRAI  = 6'd19;
  localparam logic [OP_SIZE_LOG-1:0] OP_ADD   = 6'd20;
  localparam logic [OP_SIZE_LOG-1:0] OP_SUB   = 6'd21;
  localparam logic [OP_SIZE_LOG-1:0] OP_SLL   = 6'd22;
  localparam logic [OP_SIZE_LOG-1:0] OP_SLT   = 6'd23;
  localparam logic [OP_SIZE_LOG-1:0] OP_SLTU  = 6'd24;
  localparam logic [OP_SIZE_LOG-1:0] OP_XOR   = 6'd25;
  localparam logic [OP_SIZE_LOG-1:0] OP_SRL   = 6'd26;
  localparam logic [OP_SIZE_LOG-1:0] OP_SRA   = 6'd27;
  localparam logic [OP_SIZE_LOG-1:0] OP_OR    = 6'd28;
  localparam logic [OP_SIZE_LOG-1:0] OP_AND   = 6'd29;

  typedef struct packed {
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } alu_out_t;

  // Shift-immediate ops take their shamt from imm[4:0] instead of vk[4:0].
  function automatic logic is_shift_imm(input logic [OP_SIZE_LOG-1:0] op);
    return (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_stage_core.sv
// ============================================================================
// alu_core : combinational op decode -> rd value, jump decision, next PC
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_core
  import alu_stage_pkg::*;
(
  input  logic [OP_SIZE_LOG-1:0] op,
  input  logic [31:0]            vj,
  input  logic [31:0]            vk,
  input  logic [31:0]            imm,
  input  logic [31:0]            pc,
  output logic [31:0]            value,
  output logic                   jump,
  output logic [31:0]            target
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus_imm;
  logic [4:0]  w_shamt;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;
  logic        w_take;

  assign w_pc_plus4    = pc + 32'd4;
  assign w_pc_plus_imm = pc + imm;
  assign w_shamt       = is_shift_imm(op) ? imm[4:0] : vk[4:0];
  assign w_lt_s        = $signed(vj) < $signed(vk);
  assign w_lt_u        = vj < vk;
  assign w_eq          = vj == vk;

  always_comb begin
    value  = 32'd0;
    jump   = 1'b0;
    target = w_pc_plus4;
    w_take = 1'b0;
    case (op)
      OP_LUI:   value = imm;
      OP_AUIPC: value = w_pc_plus_imm;
      OP_JAL: begin
        value  = w_pc_plus4;
        jump   = 1'b1;
        target = w_pc_plus_imm;
      end
      OP_JALR: begin
        value  = w_pc_plus4;
        jump   = 1'b1;
        target = (vj + imm) & ~32'h1;
      end
      OP_BEQ:   w_take = w_eq;
      OP_BNE:   w_take = !w_eq;
      OP_BLT:   w_take = w_lt_s;
      OP_BGE:   w_take = !w_lt_s;
      OP_BLTU:  w_take = w_lt_u;
      OP_BGEU:  w_take = !w_lt_u;
      OP_ADDI:  value = vj + imm;
      OP_SLTI:  value = {31'd0, $signed(vj) < $signed(imm)};
      OP_SLTIU: value = {31'd0, vj < imm};
      OP_XORI:  value = vj ^ imm;
      OP_ORI:   value = vj | imm;
      OP_ANDI:  value = vj & imm;
      OP_ADD:   value = vj + vk;
      OP_SUB:   value = vj - vk;
      OP_SLT:   value = {31'd0, w_lt_s};
      OP_SLTU:  value = {31'd0, w_lt_u};
      OP_XOR:   value = vj ^ vk;
      OP_OR:    value = vj | vk;
      OP_AND:   value = vj & vk;
      OP_SLL, OP_SLLI: value = vj << w_shamt;
      OP_SRL, OP_SRLI: value = vj >> w_shamt;
      OP_SRA, OP_SRAI: value = $signed(vj) >>> w_shamt;
      default: value = 32'd0;
    endcase
    // Branches share one taken flag; value stays 0 for them.
    if (w_take) begin
      jump   = 1'b1;
      target = w_pc_plus_imm;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_stage.sv
// ============================================================================
// alu_stage : registered ALU stage with capture / flush / stall control
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_stage
  import alu_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    pred_fail_flag,
  input  logic                    ALU_enable,
  input  logic [OP_SIZE_LOG-1:0]  op_to_ALU,
  input  logic [31:0]             vj_to_ALU,
  input  logic [31:0]             vk_to_ALU,
  input  logic [31:0]             imm_to_ALU,
  input  logic [ROB_SIZE_LOG-1:0] robid_to_ALU,
  input  logic [31:0]             curpc_to_ALU,
  output logic                    ALU_valid,
  output logic [31:0]             ALU_value,
  output logic [ROB_SIZE_LOG-1:0] ALU_robid,
  output logic                    ALU_jump,
  output logic [31:0]             ALU_target
);

  alu_out_t                w_res;
  logic                    r_valid;
  alu_out_t                r_res;
  logic [ROB_SIZE_LOG-1:0] r_robid;

  alu_core u_core (
    .op     (op_to_ALU),
    .vj     (vj_to_ALU),
    .vk     (vk_to_ALU),
    .imm    (imm_to_ALU),
    .pc     (curpc_to_ALU),
    .value  (w_res.value),
    .jump   (w_res.jump),
    .target (w_res.target)
  );

  // rdy low freezes everything, including a pending valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_robid <= '0;
    end else if (rdy) begin
      if (pred_fail_flag) begin
        r_valid <= 1'b0;
      end else if (ALU_enable) begin
        r_valid <= 1'b1;
        r_res   <= w_res;
        r_robid <= robid_to_ALU;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ALU_valid  = r_valid;
  assign ALU_value  = r_res.value;
  assign ALU_jump   = r_res.jump;
  assign ALU_target = r_res.target;
  assign ALU_robid  = r_robid;

endmodule

`default_nettype wire

// File: doc/alu_stage.md
# alu_stage

Execution stage directly downstream of the reservation station. It accepts one ready instruction per cycle on the RS dispatch bus, computes the integer result, jump decision and jump target, and registers them. The registered result is broadcast on the ALU result bus (`ALU_valid` / `ALU_value` / `ALU_robid`), which the RS, load/store buffer and ROB snoop. Branch and jump outcomes (`ALU_jump`, `ALU_target`) go to the ROB for misprediction handling.

## Interface
Parameters: none; all widths come from `utils.v` (`OP_SIZE_LOG`, `ROB_SIZE_LOG`, `OP_*` encodings).

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. `rst == 0` clears state immediately, independent of `clk`.
- `rdy`  in  1  global ready. When 0, all state freezes.
- `pred_fail_flag`  in  1  synchronous flush from the ROB.
- `ALU_enable`  in  1  dispatch valid from the RS.
- `op_to_ALU`  in  `OP_SIZE_LOG`  operation code.
- `vj_to_ALU`, `vk_to_ALU`  in  32  source operand values.
- `imm_to_ALU`  in  32  sign-extended immediate; for shift-immediate ops, the shamt is in bits [4:0].
- `robid_to_ALU`  in  `ROB_SIZE_LOG`  destination ROB tag.
- `curpc_to_ALU`  in  32  PC of the instruction.
- `ALU_valid`  out  1  result valid, high for one cycle per instruction.
- `ALU_value`  out  32  rd writeback value.
- `ALU_robid`  out  `ROB_SIZE_LOG`  tag of the result.
- `ALU_jump`  out  1  control transfer taken.
- `ALU_target`  out  32  next PC for the instruction.

## Operation
- **Capture.** On a clock edge where `rdy == 1`, `pred_fail_flag == 0` and `ALU_enable == 1`, register the computed outputs and set `ALU_valid = 1`.
- **Idle.** On an edge where `rdy == 1` and `ALU_enable == 0`, set `ALU_valid = 0`. The other outputs keep their last values.
- **Result per op:**
  - LUI: `imm`.
  - AUIPC: `pc + imm`.
  - JAL / JALR: `pc + 4`.
  - ADD(I), SUB, XOR(I), OR(I), AND(I): standard 32-bit results, wrap-around and no overflow trap.
  - SLT(I): signed compare, result 0 or 1.
  - SLTU / SLTIU: unsigned compare, result 0 or 1. SLTIU compares against the sign-extended immediate treated as unsigned.
  - SLL / SRL / SRA: shift amount is `vk[4:0]`. SLLI / SRLI / SRAI: shift amount is `imm[4:0]`. SRA and SRAI are arithmetic shifts.
  - Branches: `ALU_value = 0`.
- **Jump decision:**
  - `ALU_jump = 1` for JAL and JALR.
  - For BEQ, BNE, BLT, BGE, BLTU, BGEU, `ALU_jump` is the branch condition on `vj`, `vk` (signed compare for BLT/BGE, unsigned for BLTU/BGEU).
  - `ALU_jump = 0` for all other ops.
- **Target:**
  - JAL: `pc + imm`.
  - JALR: `(vj + imm) & ~32'h1`.
  - Taken branch: `pc + imm`.
  - Everything else: `pc + 4`.
- **Flush.** `pred_fail_flag == 1` (with `rdy == 1`) forces `ALU_valid = 0` on that edge and discards any concurrent dispatch. The flush has priority over `ALU_enable`.
- **Reset.** Asynchronous assertion (`rst == 0`) sets `ALU_valid`, `ALU_jump` and `ALU_value` to 0, `ALU_robid` to 0, and `ALU_target` to 0. Deassertion is synchronised externally, so the block is safe mid-operation: any in-flight result is dropped.
- **Undefined op codes.** Produce `ALU_value = 0`, `ALU_jump = 0`, `ALU_target = pc + 4`, with `ALU_valid` still asserted.

## Timing
- Latency: exactly one cycle. Inputs sampled at edge N appear on the outputs after edge N and are valid until edge N+1.
- Throughput: one instruction per cycle. Back-to-back dispatches produce back-to-back `ALU_valid` pulses with no bubble.
- No backpressure. Consumers must accept `ALU_valid` in the cycle it is high.
- Stall (`rdy == 0`): all outputs hold exactly, including `ALU_valid = 1` if it was 1. Consumers freeze under the same `rdy`, so a held pulse is counted once.
- Path: all arithmetic is a single combinational level into the output registers. The 32-bit adders, comparators and barrel shifter must close timing in one cycle.

## Structure
- `utils.v` owns the `OP_*` encodings, `OP_SIZE_LOG` and `ROB_SIZE_LOG`. Add no new constants to it.
- Sub-module `alu_core`: purely combinational. It maps op, vj, vk, imm and pc to value, jump and target.
- `alu_stage` contains only the output registers, the capture/flush/stall control and the asynchronous reset.

## Test plan
- **Reset mid-stream.** Drive `rst = 0` asynchronously between edges while `ALU_valid = 1` -> all outputs read 0 immediately, before the next edge.
- **ADD, then SRAI back-to-back.**
  - ADD with `vj = 32'h7FFF_FFFF`, `vk = 1`, robid 3 -> next cycle `ALU_value = 32'h8000_0000`, `ALU_robid = 3`.
  - SRAI with `vj = 32'hF000_0000`, `imm = 4` in the following cycle -> `ALU_value = 32'hFF00_0000`.
  - `ALU_valid` stays high for 2 consecutive cycles.
- **Branches at pc `32'h100`, `imm = -8`.**
  - BLT with `vj = -1`, `vk = 0` -> `ALU_jump = 1`, `ALU_target = 32'hF8`.
  - BLTU with the same operands -> `ALU_jump = 0`, `ALU_target = 32'h104`.
- **JALR.** `vj = 32'h1001`, `imm = 2`, pc `32'h40` -> `ALU_value = 32'h44`, `ALU_target = 32'h1002`, `ALU_jump = 1`.
- **Flush priority.** Assert `pred_fail_flag` together with `ALU_enable` (ADD, robid 5) -> `ALU_valid = 0` next cycle and tag 5 never appears.
- **Stall.** `rdy` low for 3 cycles after a SLTIU with `vj = 5`, `imm = -1` (`ALU_value = 1`) -> outputs hold unchanged for all 3 cycles. A new `ALU_enable` presented during the stall is not captured until `rdy` returns to 1.
